bus_initiator: RTL

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator.sv | 111 +++++++++++
 1 files changed

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - register-bus initiator running a two-phase (data, status) four-edge handshake
// All outputs are registered from the next-state value so they line up with the state they belong to.
module bus_initiator #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] rsp_status,
  output logic                  rsp_timeout,
  output logic                  handshake_1,
  input  logic                  handshake_2,
  output logic                  RW,
  output logic [ADDR_WIDTH-1:0] reg_address,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, H1_DATA, REL_DATA, H1_STAT, REL_STAT, RESP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wait_st, ack_seen, expired;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_st   = 1'b0;
    ack_seen  = 1'b0;
    expired   = 1'b0;
    case (state)
      IDLE: if (cmd_valid) state_nxt = H1_DATA;
      H1_DATA: begin
        wait_st  = 1'b1;
        ack_seen = handshake_2;
        if (ack_seen) state_nxt = REL_DATA;
      end
      REL_DATA: begin
        wait_st  = 1'b1;
        ack_seen = !handshake_2;
        if (ack_seen) state_nxt = H1_STAT;
      end
      H1_STAT: begin
        wait_st  = 1'b1;
        ack_seen = handshake_2;
        if (ack_seen) state_nxt = REL_STAT;
      end
      REL_STAT: begin
        wait_st  = 1'b1;
        ack_seen = !handshake_2;
        if (ack_seen) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // An ack arriving on the last allowed cycle still wins over the timeout.
    expired = wait_st && !ack_seen && (cnt >= CNT_LIMIT);
    if (expired) state_nxt = RESP;

    if (state_nxt != state)
      cnt_nxt = '0;
    else if (wait_st && (cnt != '1))
      cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      handshake_1 <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
      rsp_status  <= '0;
      RW          <= 1'b0;
      reg_address <= '0;
      data_out    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cmd_ready   <= (state_nxt == IDLE);
      handshake_1 <= (state_nxt == H1_DATA) || (state_nxt == H1_STAT);
      rsp_valid   <= (state_nxt == RESP);

      if (state == IDLE && cmd_valid) begin
        RW          <= cmd_rw;
        reg_address <= cmd_addr;
        data_out    <= cmd_data;
      end
      if (state == H1_DATA && handshake_2) rsp_data   <= data_in;
      if (state == H1_STAT && handshake_2) rsp_status <= data_in;
      if (state_nxt == RESP && state != RESP) rsp_timeout <= expired;
    end
  end

endmodule
